// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU / load) round-robin write-back arbiter with a registered register-bank write stage.
// Optional read bypass of the pending write when WB_BYPASS_EN is defined.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              A_Valid,
  input  logic [ADDR_W-1:0] A_Dest,
  input  logic [DATA_W-1:0] A_Data,
  output logic              A_Ready,
  input  logic              M_Valid,
  input  logic [ADDR_W-1:0] M_Dest,
  input  logic [DATA_W-1:0] M_Data,
  output logic              M_Ready,
  output logic              Write_En,
  output logic [ADDR_W-1:0] Add_Dest,
  output logic [DATA_W-1:0] Write_Data,
  input  logic [ADDR_W-1:0] Add_A,
  input  logic [ADDR_W-1:0] Add_B,
  input  logic [DATA_W-1:0] Info_A_In,
  input  logic [DATA_W-1:0] Info_B_In,
  output logic [DATA_W-1:0] Info_A,
  output logic [DATA_W-1:0] Info_B
);

  logic              last_grant_q, last_grant_d;  // 0 = ALU, 1 = MEM
  logic              we_q, we_d;
  logic [ADDR_W-1:0] add_dest_q, add_dest_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              a_rdy, m_rdy, xfer;
  logic [ADDR_W-1:0] sel_dest;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    a_rdy = 1'b0;
    m_rdy = 1'b0;
    if (!RST) begin
      a_rdy = A_Valid && (!M_Valid || last_grant_q);
      m_rdy = M_Valid && (!A_Valid || !last_grant_q);
    end
    xfer     = a_rdy || m_rdy;
    sel_dest = m_rdy ? M_Dest : A_Dest;
    sel_data = m_rdy ? M_Data : A_Data;

    last_grant_d = last_grant_q;
    add_dest_d   = add_dest_q;
    wdata_d      = wdata_q;
    we_d         = 1'b0;
    if (xfer) begin
      last_grant_d = m_rdy;
      add_dest_d   = sel_dest;
      wdata_d      = sel_data;
      // x0 is hardwired: accept the request but never write it
      we_d         = (sel_dest != '0);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      add_dest_q   <= '0;
      wdata_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      add_dest_q   <= add_dest_d;
      wdata_q      <= wdata_d;
    end
  end

  assign A_Ready    = a_rdy;
  assign M_Ready    = m_rdy;
  assign Write_En   = we_q;
  assign Add_Dest   = add_dest_q;
  assign Write_Data = wdata_q;

`ifdef WB_BYPASS_EN
  assign Info_A = (we_q && add_dest_q == Add_A && Add_A != '0) ? wdata_q : Info_A_In;
  assign Info_B = (we_q && add_dest_q == Add_B && Add_B != '0) ? wdata_q : Info_B_In;
`else
  logic unused_addr;
  assign unused_addr = ^{Add_A, Add_B};
  assign Info_A = Info_A_In;
  assign Info_B = Info_B_In;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: behavioural model checked every cycle plus literal scenario checks.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          A_Valid = 1'b0, M_Valid = 1'b0;
  logic [AW-1:0] A_Dest = '0, M_Dest = '0, Add_A = '0, Add_B = '0;
  logic [DW-1:0] A_Data = '0, M_Data = '0, Info_A_In = '0, Info_B_In = '0;
  logic          A_Ready, M_Ready, Write_En;
  logic [AW-1:0] Add_Dest;
  logic [DW-1:0] Write_Data, Info_A, Info_B;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST),
    .A_Valid(A_Valid), .A_Dest(A_Dest), .A_Data(A_Data), .A_Ready(A_Ready),
    .M_Valid(M_Valid), .M_Dest(M_Dest), .M_Data(M_Data), .M_Ready(M_Ready),
    .Write_En(Write_En), .Add_Dest(Add_Dest), .Write_Data(Write_Data),
    .Add_A(Add_A), .Add_B(Add_B), .Info_A_In(Info_A_In), .Info_B_In(Info_B_In),
    .Info_A(Info_A), .Info_B(Info_B)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who is owed the grant, and what the bank write looks like one cycle later
  bit          mdl_mem_last = 1'b1;
  bit          mdl_we = 1'b0;
  bit          mdl_known = 1'b1;
  int unsigned mdl_dest = 0, mdl_data = 0;

  function automatic logic [1:0] exp_grant(bit av, bit mv);
    // {alu, mem}
    if (RST) return 2'b00;
    if (av && mv) return mdl_mem_last ? 2'b10 : 2'b01;
    return {av, mv};
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mdl_mem_last = 1'b1; mdl_we = 1'b0; mdl_dest = 0; mdl_data = 0; mdl_known = 1'b1;
    end else begin
      logic [1:0] g;
      g = exp_grant(A_Valid, M_Valid);
      mdl_we = 1'b0;
      if (g != 2'b00) begin
        mdl_mem_last = g[0];
        mdl_dest = g[0] ? int'(M_Dest) : int'(A_Dest);
        mdl_data = g[0] ? M_Data : A_Data;
        mdl_we = (mdl_dest != 0);
        // address/data latched for an x0 request are not observable; stop tracking them
        mdl_known = mdl_we;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      logic [1:0] g;
      logic [DW-1:0] ea, eb;
      g = exp_grant(A_Valid, M_Valid);
      check("a_ready", A_Ready, g[1]);
      check("m_ready", M_Ready, g[0]);
      check("write_en", Write_En, mdl_we);
      if (mdl_known) begin
        check("add_dest", Add_Dest, mdl_dest);
        check("write_data", Write_Data, mdl_data);
      end
      ea = Info_A_In; eb = Info_B_In;
`ifdef WB_BYPASS_EN
      if (mdl_we && Add_A != 0 && int'(Add_A) == mdl_dest) ea = mdl_data;
      if (mdl_we && Add_B != 0 && int'(Add_B) == mdl_dest) eb = mdl_data;
`endif
      check("info_a", Info_A, ea);
      check("info_b", Info_B, eb);
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic drive(input bit av, input int ad, input int adat, input bit mv, input int md, input int mdat);
    A_Valid = av; A_Dest = AW'(ad); A_Data = DW'(adat);
    M_Valid = mv; M_Dest = AW'(md); M_Data = DW'(mdat);
  endtask

  logic [1:0] vec_v [8] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10};

  initial begin
    #1 RST = 1'b1;
    #2;
    check("rst_we", Write_En, 1'b0);
    check("rst_dest", Add_Dest, 0);
    check("rst_data", Write_Data, 0);
    A_Valid = 1'b1; M_Valid = 1'b1; #1;
    check("rst_aready", A_Ready, 1'b0);
    check("rst_mready", M_Ready, 1'b0);
    drive(0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    tick(); tick();
    RST = 1'b0;
    tick();

    // contention straight after reset: ALU first, then MEM
    drive(1, 3, 5, 1, 4, 8); #1;
    check("c1_aready", A_Ready, 1'b1);
    check("c1_mready", M_Ready, 1'b0);
    tick();
    check("c2_mready", M_Ready, 1'b1);
    check("c2_we", Write_En, 1'b1);
    check("c2_dest", Add_Dest, 3);
    check("c2_data", Write_Data, 5);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("c3_we", Write_En, 1'b1);
    check("c3_dest", Add_Dest, 4);
    check("c3_data", Write_Data, 8);
    tick();

    // single ALU request, with read-port compare against the pending write
    drive(1, 1, 20, 0, 0, 0); #1;
    check("s_aready", A_Ready, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    Add_A = 5'd1; Info_A_In = 32'd123; Add_B = 5'd2; Info_B_In = 32'd456;
    check("s_we", Write_En, 1'b1);
    check("s_dest", Add_Dest, 1);
    check("s_data", Write_Data, 20);
    #1;
`ifdef WB_BYPASS_EN
    check("s_info_a", Info_A, 20);
`else
    check("s_info_a", Info_A, 123);
`endif
    check("s_info_b", Info_B, 456);
    tick();

    // pending write of 4 to r7 seen on port A; r0 never bypasses
    drive(1, 7, 4, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    Add_A = 5'd7; Info_A_In = 32'd0; #1;
`ifdef WB_BYPASS_EN
    check("bp_info_a", Info_A, 4);
`else
    check("bp_info_a", Info_A, 0);
`endif
    Add_A = 5'd0; Info_A_In = 32'd99; #1;
    check("bp_x0_info_a", Info_A, 99);
    tick();

    // load to x0: accepted but not written
    drive(0, 0, 0, 1, 0, 30); #1;
    check("x0_mready", M_Ready, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("x0_we", Write_En, 1'b0);
    tick();

    // idle after a write: address and data hold
    drive(1, 2, 25, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("idle_we0", Write_En, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_we", Write_En, 1'b0);
      check("idle_dest", Add_Dest, 2);
      check("idle_data", Write_Data, 25);
    end

    // ALU won last; MEM takes the next contention, then reset lands mid-write
    drive(1, 9, 77, 1, 10, 88);
    tick();
    check("mr_we", Write_En, 1'b1);
    check("mr_dest", Add_Dest, 10);
    #2 RST = 1'b1; #1;
    check("mr_we_async", Write_En, 1'b0);
    check("mr_aready", A_Ready, 1'b0);
    check("mr_mready", M_Ready, 1'b0);
    tick();
    RST = 1'b0; #1;
    check("post_rst_aready", A_Ready, 1'b1);
    check("post_rst_mready", M_Ready, 1'b0);
    tick();

    for (int i = 0; i < 8; i++) begin
      drive(vec_v[i][1], (i == 4) ? 0 : i + 10, 100 + i, vec_v[i][0], i + 20, 200 + i);
      Add_A = AW'(i + 10); Add_B = AW'(i + 19);
      Info_A_In = DW'(i * 3); Info_B_In = DW'(i * 5);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port A_Valid  input  1  ALU requester has a write-back pending.
REQ-006 SHALL have port A_Dest  input  ADDR_W  ALU destination register.
REQ-007 SHALL have port A_Data  input  DATA_W  ALU result.
REQ-008 SHALL have port A_Ready  output  1  ALU request accepted this cycle.
REQ-009 SHALL have port M_Valid  input  1  memory/load requester has a write-back pending.
REQ-010 SHALL have port M_Dest  input  ADDR_W  load destination register.
REQ-011 SHALL have port M_Data  input  DATA_W  load data.
REQ-012 SHALL have port M_Ready  output  1  load request accepted this cycle.
REQ-013 SHALL have port Write_En  output  1  register bank write enable.
REQ-014 SHALL have port Add_Dest  output  ADDR_W  register bank write address.
REQ-015 SHALL have port Write_Data  output  DATA_W  register bank write data.
REQ-016 SHALL have ports Add_A and Add_B  input  ADDR_W  register bank read addresses, for the bypass compare.
REQ-017 SHALL have ports Info_A_In and Info_B_In  input  DATA_W  raw register bank read data.
REQ-018 SHALL have ports Info_A and Info_B  output  DATA_W  read data delivered to the datapath.

Function
REQ-019 A transfer SHALL occur for a requester in a cycle where its Valid and Ready are both 1.
REQ-020 A_Ready and M_Ready SHALL be combinational from the Valid inputs and the pointer, and SHALL never both be 1.
REQ-021 If exactly one Valid is 1, that requester SHALL get Ready=1.
REQ-022 If both Valid are 1, the requester not granted last SHALL get Ready=1 (round-robin).
REQ-023 A 1-bit pointer Last_Grant (0=ALU, 1=MEM) SHALL update only on a transfer.
REQ-024 The write stage SHALL be registered with 1-cycle latency: a transfer in cycle N sets Write_En, Add_Dest and Write_Data in cycle N+1.
REQ-025 In a cycle with no transfer, Write_En SHALL be 0 the next cycle, and Add_Dest and Write_Data SHALL hold their values.
REQ-026 A transfer with Dest=0 SHALL be accepted (Ready=1, pointer updates), with Write_En=0 the next cycle (x0 suppression).
REQ-027 Throughput SHALL be one transfer per cycle sustained; a losing requester SHALL wait at most 1 cycle while both remain valid.
REQ-028 Requesters SHALL hold Dest and Data stable while Valid=1 and Ready=0; the block SHALL NOT buffer unaccepted requests.

Reset
REQ-029 While RST=1, A_Ready and M_Ready SHALL be 0.
REQ-030 While RST=1, Write_En, Add_Dest and Write_Data SHALL be 0.
REQ-031 While RST=1, Last_Grant SHALL be 1 (MEM), so the ALU wins the first contention.
REQ-032 Asserting RST mid-operation SHALL clear Write_En immediately, without waiting for a clock edge.
REQ-033 A request not accepted before reset SHALL be lost, and SHALL be re-presented after reset.

Configuration
REQ-034 Macro WB_BYPASS_EN defined: Info_A SHALL be Write_Data when Write_En=1, Add_Dest==Add_A and Add_A!=0; otherwise Info_A SHALL be Info_A_In. Info_B SHALL follow the same rule using Add_B and Info_B_In.
REQ-035 Macro WB_BYPASS_EN undefined: Info_A SHALL equal Info_A_In and Info_B SHALL equal Info_B_In (pass-through, no compare logic).

Verification
REQ-036 Scenario: after reset, A_Valid=1, A_Dest=1, A_Data=20 -> A_Ready=1 the same cycle; Write_En=1, Add_Dest=1, Write_Data=20 the next cycle.
REQ-037 Scenario: both valid with dests 3/4, data 5/8, held 2 cycles -> ALU accepted in cycle 1 and MEM in cycle 2; writes to 3 and then to 4 on consecutive cycles.
REQ-038 Scenario: M_Valid=1, M_Dest=0, M_Data=30 -> M_Ready=1 and Write_En=0 the next cycle.
REQ-039 Scenario: RST asserted mid-write, between clock edges -> Write_En=0 and both Ready=0 immediately; after release, the first contention goes to the ALU.
REQ-040 Scenario: WB_BYPASS_EN defined, write to 7 of value 4 pending, Add_A=7, Info_A_In=0 -> Info_A=4; with Add_A=0 -> Info_A=Info_A_In.
REQ-041 Scenario: no Valid for 3 cycles after writing 25 to register 2 -> Write_En=0, with Add_Dest=2 and Write_Data=25 held.
